// File: rtl/time_display_driver.sv
// time_display_driver: BCD conversion and 4-digit multiplexed common-anode
// seven-segment driver for an HH:MM clock. The colon is the hour-units dp.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank a leading hour zero).
module time_display_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic       running,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_LZ = 1'b1;
`else
  localparam bit BLANK_LZ = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, LOAD = 2'd2} state_t;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h40;
      4'd1: enc = 7'h79;
      4'd2: enc = 7'h24;
      4'd3: enc = 7'h30;
      4'd4: enc = 7'h19;
      4'd5: enc = 7'h12;
      4'd6: enc = 7'h02;
      4'd7: enc = 7'h78;
      4'd8: enc = 7'h00;
      4'd9: enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  // Scan timing
  logic [SW-1:0] scan_cnt_q;
  logic [1:0]    idx_q;
  logic          scan_tc;
  logic          start_w;

  // Converter
  state_t     state_q, state_d;
  logic       pend_q, pend_d;
  logic [4:0] hw_q, hw_d;
  logic [5:0] mw_q, mw_d;
  logic [1:0] ht_q, ht_d;
  logic [2:0] mt_q, mt_d;
  logic       run_w_q, run_w_d;
  logic       hoor_q, hoor_d;
  logic       moor_q, moor_d;
  logic       load;

  // Display buffer
  logic [3:0] hrt_q, hru_q, mnt_q, mnu_q;
  logic       hr_oor_q, mn_oor_q, run_b_q, valid_q;

  // Blink
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;

  // Registered outputs
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  assign scan_tc = (scan_cnt_q == SW'(SCAN_DIV - 1));
  assign start_w = scan_tc && (idx_q == 2'd3);

  // Digit scan counter and index; idx 0 is hour tens, so frames run digit 3..0
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_tc) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SW'(1);
    end
  end

  // Converter state and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b1;
      hw_q    <= '0;
      mw_q    <= '0;
      ht_q    <= '0;
      mt_q    <= '0;
      run_w_q <= 1'b0;
      hoor_q  <= 1'b0;
      moor_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hw_q    <= hw_d;
      mw_q    <= mw_d;
      ht_q    <= ht_d;
      mt_q    <= mt_d;
      run_w_q <= run_w_d;
      hoor_q  <= hoor_d;
      moor_q  <= moor_d;
    end
  end

  // Repeated-subtraction BCD conversion; leaves CONV once post-subtraction values are < 10
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    hw_d    = hw_q;
    mw_d    = mw_q;
    ht_d    = ht_q;
    mt_d    = mt_q;
    run_w_d = run_w_q;
    hoor_d  = hoor_q;
    moor_d  = moor_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_w || pend_q) begin
          pend_d  = 1'b0;
          hw_d    = hour;
          mw_d    = minute;
          run_w_d = running;
          hoor_d  = (hour > 5'd23);
          moor_d  = (minute > 6'd59);
          ht_d    = '0;
          mt_d    = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (hw_q >= 5'd10) begin
          hw_d = hw_q - 5'd10;
          ht_d = ht_q + 2'd1;
        end
        if (mw_q >= 6'd10) begin
          mw_d = mw_q - 6'd10;
          mt_d = mt_q + 3'd1;
        end
        if ((hw_d < 5'd10) && (mw_d < 6'd10)) state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display buffer written once per conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      hrt_q    <= '0;
      hru_q    <= '0;
      mnt_q    <= '0;
      mnu_q    <= '0;
      hr_oor_q <= 1'b0;
      mn_oor_q <= 1'b0;
      run_b_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else if (load) begin
      hrt_q    <= {2'b00, ht_q};
      hru_q    <= hw_q[3:0];
      mnt_q    <= {1'b0, mt_q};
      mnu_q    <= mw_q[3:0];
      hr_oor_q <= hoor_q;
      mn_oor_q <= moor_q;
      run_b_q  <= run_w_q;
      valid_q  <= 1'b1;
    end
  end

  // Colon blink; held in the on phase while the buffered clock is stopped
  always_ff @(posedge clk) begin
    if (rst || !run_b_q) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  // Segment/anode/dp selection for the current digit
  always_comb begin
    an_d  = '1;
    seg_d = '1;
    dp_d  = 1'b1;
    if (valid_q) begin
      an_d = ~(4'b1000 >> idx_q);
      dp_d = !((idx_q == 2'd1) && phase_q);
      case (idx_q)
        2'd0: seg_d = hr_oor_q ? 7'h3F :
                      ((BLANK_LZ && (hrt_q == 4'd0)) ? 7'h7F : enc(hrt_q));
        2'd1: seg_d = hr_oor_q ? 7'h3F : enc(hru_q);
        2'd2: seg_d = mn_oor_q ? 7'h3F : enc(mnt_q);
        default: seg_d = mn_oor_q ? 7'h3F : enc(mnu_q);
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Directed bench for time_display_driver with SCAN_DIV=16, BLINK_DIV=8.
module tb_time_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] hour;
  logic [5:0] minute;
  logic       running;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;

  time_display_driver #(.SCAN_DIV(16), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst), .hour(hour), .minute(minute), .running(running),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a given anode pattern; returns 0 on timeout
  task automatic wait_an(input logic [3:0] pat, input logic want_eq, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((an == pat) == want_eq) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Align to a frame start, then record one full frame
  task automatic sample_frame(output logic [6:0] s3, output logic [6:0] s2,
                              output logic [6:0] s1, output logic [6:0] s0,
                              output int dp2_low, output int dp_other_low);
    bit ok;
    s3 = 'x; s2 = 'x; s1 = 'x; s0 = 'x;
    dp2_low = 0;
    dp_other_low = 0;
    wait_an(4'b1110, 1'b1, ok);
    if (ok) wait_an(4'b1110, 1'b0, ok);
    if (!ok) chk("frame_sync", 32'(an), 32'hE);
    for (int i = 0; i < 64; i++) begin
      if (i != 0) @(negedge clk);
      case (an)
        4'b0111: s3 = seg;
        4'b1011: s2 = seg;
        4'b1101: s1 = seg;
        4'b1110: s0 = seg;
        default: ;
      endcase
      if (an == 4'b1011) begin
        if (dp == 1'b0) dp2_low++;
      end else if (dp == 1'b0) begin
        dp_other_low++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0,
                             input int e_dp2, output int dp2_low);
    logic [6:0] s3, s2, s1, s0;
    int other;
    sample_frame(s3, s2, s1, s0, dp2_low, other);
    chk({tag, "_d3"}, 32'(s3), 32'(e3));
    chk({tag, "_d2"}, 32'(s2), 32'(e2));
    chk({tag, "_d1"}, 32'(s1), 32'(e1));
    chk({tag, "_d0"}, 32'(s0), 32'(e0));
    chk({tag, "_dp_other"}, 32'(other), 32'd0);
    if (e_dp2 >= 0) chk({tag, "_dp2_low"}, 32'(dp2_low), 32'(e_dp2));
  endtask

  initial begin
    bit ok;
    int n;
    int d2;
    int bad;
    logic [6:0] lz;
`ifdef LEADING_ZERO_BLANK_EN
    lz = 7'h7F;
`else
    lz = 7'h40;
`endif

    // Reset held for three cycles
    rst = 1'b1; hour = 5'd12; minute = 6'd34; running = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);

    // Release: buffer invalid at first, then the pending start loads quickly
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an_blank", 32'(an), 32'hF);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (an != 4'b1111) begin ok = 1'b1; break; end
    end
    chk("first_load_bound", 32'(ok), 32'h1);

    // 12:34 stopped: steady colon, dp only on digit 2
    check_frame("t1234", 7'h79, 7'h24, 7'h30, 7'h19, 16, d2);

    // 23:59: conversion latency from start pulse to LOAD
    hour = 5'd23; minute = 6'd59;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.start_w == 1'b1) begin ok = 1'b1; break; end
    end
    chk("start_seen", 32'(ok), 32'h1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (dut.state_q == 2'd2) break;
    end
    chk("load_latency", 32'(n), 32'd6);
    check_frame("t2359", 7'h24, 7'h30, 7'h12, 7'h10, 16, d2);

    // 25:63: all dashes
    hour = 5'd25; minute = 6'd63;
    check_frame("flush", 7'h3F, 7'h3F, 7'h3F, 7'h3F, -1, d2);
    check_frame("t2563", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 16, d2);

    // Change to 07:05 mid-frame; rest of this frame must stay dashed
    wait_an(4'b1011, 1'b1, ok);
    chk("mid_sync", 32'(ok), 32'h1);
    hour = 5'd7; minute = 6'd5;
    bad = 0;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (an == 4'b0111) begin ok = 1'b1; break; end
      if (an != 4'b1111 && seg != 7'h3F) bad++;
      @(negedge clk);
    end
    chk("mid_wrap_seen", 32'(ok), 32'h1);
    chk("mid_frame_unchanged", 32'(bad), 32'd0);
    check_frame("t0705", lz, 7'h78, 7'h40, 7'h12, 16, d2);

    // Running: colon blinks with 8-cycle half-period
    running = 1'b1;
    check_frame("run_flush", lz, 7'h78, 7'h40, 7'h12, -1, d2);
    check_frame("run", lz, 7'h78, 7'h40, 7'h12, 8, d2);
    check_frame("run2", lz, 7'h78, 7'h40, 7'h12, 8, d2);

    // Stop again: steady colon, blink counter held
    running = 1'b0;
    check_frame("stop_flush", lz, 7'h78, 7'h40, 7'h12, -1, d2);
    check_frame("stop", lz, 7'h78, 7'h40, 7'h12, 16, d2);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.blink_cnt_q != 0) bad++;
    end
    chk("blink_cnt_held", 32'(bad), 32'd0);

    // Mid-operation reset blanks immediately
    wait_an(4'b1011, 1'b1, ok);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_dp", 32'(dp), 32'h1);
    rst = 1'b0;
    check_frame("after_rst", lz, 7'h78, 7'h40, 7'h12, 16, d2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
